frame_issue_ctrl: RTL
=====================

FRAME_ISSUE_CTRL -- requirements
Module: frame_issue_ctrl

Interface
REQ-001 Parameter: STALL_LIMIT, 15, maximum consecutive stall cycles before fault; legal range 1..255.
REQ-002 Port: clk  in  1  sole clock; all state updates on posedge.
REQ-003 Port: reset  in  1  synchronous, active-low reset.
REQ-004 Port: dec_valid  in  1  decoded instruction present.
REQ-005 Port: dec_ready  out  1  instruction accepted this cycle.
REQ-006 Port: dec_usesA, dec_usesB  in  1 each  instruction reads the A/B source register.
REQ-007 Port: dec_aLoc, dec_bLoc  in  `REGADDR_WIDTH each  source register addresses.
REQ-008 Port: dec_writeEnable  in  1  instruction writes a destination register.
REQ-009 Port: dec_writeSelect  in  `REGADDR_WIDTH  destination register address.
REQ-010 Port: wb_valid  in  1  a writeback retires this cycle.
REQ-011 Port: wb_loc  in  `REGADDR_WIDTH  register retired by writeback.
REQ-012 Port: flush  in  1  discard in-flight state.
REQ-013 Port: frame_we  out  1  load pulse driving all field write enables of the instruction frame.
REQ-014 Port: stall  out  1  high while in STALL.
REQ-015 Port: hazard_timeout  out  1  high while in FAULT.
REQ-016 Port: pending_count  out  `REGADDR_WIDTH+1  number of scoreboard bits set.

Function
REQ-017 Scoreboard: one pending bit per register (2^`REGADDR_WIDTH bits); register 0 is never pending, and writes to it are ignored.
REQ-018 Hazard: dec_valid & ((dec_usesA & pending[dec_aLoc]) | (dec_usesB & pending[dec_bLoc])).
REQ-019 States: IDLE, STALL, FAULT; reset state is IDLE.
REQ-020 IDLE or STALL, dec_valid, no hazard -> dec_ready=1 and frame_we=1 combinationally in the same cycle; next state IDLE.
REQ-021 IDLE, dec_valid, hazard -> next state STALL; stall counter loads 1.
REQ-022 STALL, hazard persists -> stall counter increments; when the counter equals STALL_LIMIT, next state FAULT.
REQ-023 FAULT: dec_ready=0 and frame_we=0; exits only via flush or reset.
REQ-024 Issue with dec_writeEnable=1 and dec_writeSelect!=0 sets pending[dec_writeSelect] at that edge.
REQ-025 wb_valid clears pending[wb_loc] at the edge.
REQ-026 Same-cycle set and clear of the same register: set wins.
REQ-027 dec_ready and frame_we are 0 whenever dec_valid=0, flush=1, or reset is asserted.
REQ-028 flush: clears all pending bits and the stall counter, next state IDLE; it has priority over issue and writeback.
REQ-029 pending_count is registered and consistent with the scoreboard after every edge.

Reset
REQ-030 reset=0 at posedge: state IDLE, scoreboard cleared, stall counter 0, pending_count 0.
REQ-031 Outputs while reset=0: dec_ready=0, frame_we=0, stall=0, hazard_timeout=0.
REQ-032 Reset mid-stall or in FAULT: returns to IDLE in one edge; the stalled instruction is not issued.

Configuration
REQ-033 FRAME_ISSUE_BYPASS_EN defined: a same-cycle wb_valid whose wb_loc matches a pending source masks that source's hazard, so the instruction issues in the writeback cycle.
REQ-034 FRAME_ISSUE_BYPASS_EN undefined: hazard uses registered pending bits only, and issue occurs no earlier than the cycle after writeback.

Verification
REQ-035 Reset then dec_valid=1, writeSelect=5, writeEnable=1 -> frame_we=1 same cycle; pending_count=1 next cycle.
REQ-036 pending[5] set, dec_usesA=1, aLoc=5 -> stall=1; wb_valid with loc 5 at cycle 3 -> issue at cycle 4 (bypass off) or at cycle 3 (bypass on).
REQ-037 Hazard held with no writeback, STALL_LIMIT=15 -> hazard_timeout=1 after 15 stall cycles; flush -> IDLE and pending_count=0.
REQ-038 Issue writing reg 7 with same-cycle wb_loc=7 -> pending[7]=1 afterward; writeSelect=0 -> pending_count unchanged.
REQ-039 reset=0 asserted during STALL -> IDLE next edge, all outputs 0, and no frame_we pulse.

Source files
------------

// File: rtl/frame_issue_ctrl.sv
// Instruction issue controller: register scoreboard, hazard stall and stall-timeout fault.
// Optional same-cycle writeback bypass of source hazards: define FRAME_ISSUE_BYPASS_EN.
`ifndef REGADDR_WIDTH
`define REGADDR_WIDTH 5
`endif

module frame_issue_ctrl #(
  parameter int unsigned STALL_LIMIT = 15
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        dec_valid,
  output logic                        dec_ready,
  input  logic                        dec_usesA,
  input  logic                        dec_usesB,
  input  logic [`REGADDR_WIDTH-1:0]   dec_aLoc,
  input  logic [`REGADDR_WIDTH-1:0]   dec_bLoc,
  input  logic                        dec_writeEnable,
  input  logic [`REGADDR_WIDTH-1:0]   dec_writeSelect,
  input  logic                        wb_valid,
  input  logic [`REGADDR_WIDTH-1:0]   wb_loc,
  input  logic                        flush,
  output logic                        frame_we,
  output logic                        stall,
  output logic                        hazard_timeout,
  output logic [`REGADDR_WIDTH:0]     pending_count
);

  localparam int unsigned NREG = 1 << `REGADDR_WIDTH;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_STALL = 2'd1;
  localparam logic [1:0] S_FAULT = 2'd2;

  logic [1:0]              r_state;
  logic [1:0]              w_state_nxt;
  logic [7:0]              r_stall_cnt;
  logic [7:0]              w_stall_cnt_nxt;
  logic [NREG-1:0]         r_pending;
  logic [NREG-1:0]         w_pending_nxt;
  logic [NREG-1:0]         w_set_mask;
  logic [NREG-1:0]         w_clr_mask;
  logic [`REGADDR_WIDTH:0] r_pending_count;
  logic                    w_hazard_a;
  logic                    w_hazard_b;
  logic                    w_hazard;
  logic                    w_issue;
  logic                    w_byp_a;
  logic                    w_byp_b;

  function automatic logic [`REGADDR_WIDTH:0] popcount(input logic [NREG-1:0] v);
    logic [`REGADDR_WIDTH:0] c;
    c = {(`REGADDR_WIDTH+1){1'b0}};
    for (int i = 0; i < NREG; i++) begin
      c = c + {{`REGADDR_WIDTH{1'b0}}, v[i]};
    end
    return c;
  endfunction

`ifdef FRAME_ISSUE_BYPASS_EN
  // A register retiring this cycle no longer blocks a reader of it.
  assign w_byp_a = wb_valid & (wb_loc == dec_aLoc);
  assign w_byp_b = wb_valid & (wb_loc == dec_bLoc);
`else
  assign w_byp_a = 1'b0;
  assign w_byp_b = 1'b0;
`endif

  assign w_hazard_a = dec_usesA & r_pending[dec_aLoc] & ~w_byp_a;
  assign w_hazard_b = dec_usesB & r_pending[dec_bLoc] & ~w_byp_b;
  assign w_hazard   = dec_valid & (w_hazard_a | w_hazard_b);
  assign w_issue    = reset & ~flush & dec_valid & ~w_hazard & (r_state != S_FAULT);

  assign dec_ready      = w_issue;
  assign frame_we       = w_issue;
  assign stall          = reset & (r_state == S_STALL);
  assign hazard_timeout = reset & (r_state == S_FAULT);
  assign pending_count  = r_pending_count;

  // Set wins over clear on the same register; register 0 never becomes pending.
  assign w_set_mask = (w_issue & dec_writeEnable & (dec_writeSelect != {`REGADDR_WIDTH{1'b0}}))
                    ? ({{(NREG-1){1'b0}}, 1'b1} << dec_writeSelect) : {NREG{1'b0}};
  assign w_clr_mask = wb_valid ? ({{(NREG-1){1'b0}}, 1'b1} << wb_loc) : {NREG{1'b0}};
  assign w_pending_nxt = flush ? {NREG{1'b0}}
                       : (((r_pending & ~w_clr_mask) | w_set_mask) & ~{{(NREG-1){1'b0}}, 1'b1});

  // Next-state and stall-counter logic.
  always_comb begin
    w_state_nxt     = r_state;
    w_stall_cnt_nxt = r_stall_cnt;
    if (flush) begin
      w_state_nxt     = S_IDLE;
      w_stall_cnt_nxt = 8'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_hazard) begin
            w_state_nxt     = S_STALL;
            w_stall_cnt_nxt = 8'd1;
          end else begin
            w_state_nxt     = S_IDLE;
            w_stall_cnt_nxt = 8'd0;
          end
        end
        S_STALL: begin
          if (w_hazard) begin
            if (r_stall_cnt >= 8'(STALL_LIMIT)) begin
              w_state_nxt = S_FAULT;
            end else begin
              w_stall_cnt_nxt = r_stall_cnt + 8'd1;
            end
          end else begin
            w_state_nxt     = S_IDLE;
            w_stall_cnt_nxt = 8'd0;
          end
        end
        S_FAULT: begin
          w_state_nxt = S_FAULT;
        end
        default: begin
          w_state_nxt     = S_IDLE;
          w_stall_cnt_nxt = 8'd0;
        end
      endcase
    end
  end

  // State, scoreboard and count registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state         <= S_IDLE;
      r_stall_cnt     <= 8'd0;
      r_pending       <= {NREG{1'b0}};
      r_pending_count <= {(`REGADDR_WIDTH+1){1'b0}};
    end else begin
      r_state         <= w_state_nxt;
      r_stall_cnt     <= w_stall_cnt_nxt;
      r_pending       <= w_pending_nxt;
      r_pending_count <= popcount(w_pending_nxt);
    end
  end

endmodule
